// File: rtl/game_pkg.sv
// Shared types and grid helpers for the player movement logic.
// Directions, FSM states and edge-saturating coordinate steps live here.
package game_pkg;

    typedef enum logic [2:0] {
        DIR_NONE,
        DIR_UP,
        DIR_DOWN,
        DIR_LEFT,
        DIR_RIGHT
    } dir_t;

    typedef enum logic {
        ST_IDLE,
        ST_PENDING
    } mover_state_t;

    localparam int GRID_DIM = 4;
    localparam logic [1:0] GRID_MAX = 2'(GRID_DIM - 1);

    // Coordinates stop at the grid edge instead of wrapping.
    function automatic logic [1:0] step_dec(input logic [1:0] v);
        return (v == 2'd0) ? v : v - 2'd1;
    endfunction

    function automatic logic [1:0] step_inc(input logic [1:0] v);
        return (v == GRID_MAX) ? v : v + 2'd1;
    endfunction

endpackage

// File: rtl/button_debouncer.sv
// Synchronizes one raw active-low button, debounces it and emits a
// one-cycle pulse on each accepted press (debounced 1->0 transition).
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 250000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_raw,
    output logic press
);

    localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [1:0]       sync_q, sync_d;
    logic             db_q, db_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             press_q, press_d;

    always_comb begin
        sync_d  = {sync_q[0], btn_raw};
        db_d    = db_q;
        cnt_d   = '0;
        press_d = 1'b0;
        // Any sample matching the debounced state restarts the count.
        if (sync_q[1] != db_q) begin
            if (cnt_q == CNT_LAST) begin
                db_d    = ~db_q;
                press_d = db_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync_q  <= 2'b11;
            db_q    <= 1'b1;
            cnt_q   <= '0;
            press_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            db_q    <= db_d;
            cnt_q   <= cnt_d;
            press_q <= press_d;
        end
    end

    assign press = press_q;

endmodule

// File: rtl/player_mover.sv
// Debounces four buttons and moves the player on a 4x4 grid, committing
// each accepted move only at the start of vertical sync.
module player_mover
    import game_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 250000,
    parameter int START_ROW       = 0,
    parameter int START_COL       = 0
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       vsync,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       btn_left,
    input  logic       btn_right,
    output logic [3:0] player_address,
    output logic       frame_tick,
    output logic       move_pending
);

    localparam logic [1:0] ROW_RST = 2'(START_ROW);
    localparam logic [1:0] COL_RST = 2'(START_COL);

    logic [3:0] btn_raw;
    logic [3:0] press;

    assign btn_raw = {btn_up, btn_down, btn_left, btn_right};

    for (genvar i = 0; i < 4; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_deb (
            .clk    (clk),
            .rst    (rst),
            .btn_raw(btn_raw[i]),
            .press  (press[i])
        );
    end

    dir_t         press_dir;
    mover_state_t state_q, state_d;
    dir_t         pend_dir_q, pend_dir_d;
    logic [1:0]   row_q, row_d;
    logic [1:0]   col_q, col_d;
    logic         vsync_q, vsync_d;
    logic         frame_tick_q, frame_tick_d;

    // Same-cycle presses resolve up > down > left > right; the rest are dropped.
    always_comb begin
        press_dir = DIR_NONE;
        if (press[3])      press_dir = DIR_UP;
        else if (press[2]) press_dir = DIR_DOWN;
        else if (press[1]) press_dir = DIR_LEFT;
        else if (press[0]) press_dir = DIR_RIGHT;
    end

    always_comb begin
        state_d      = state_q;
        pend_dir_d   = pend_dir_q;
        row_d        = row_q;
        col_d        = col_q;
        vsync_d      = vsync;
        frame_tick_d = vsync_q & ~vsync;

        case (state_q)
            ST_IDLE: begin
                if (press_dir != DIR_NONE) begin
                    state_d    = ST_PENDING;
                    pend_dir_d = press_dir;
                end
            end
            ST_PENDING: begin
                // Later presses are ignored; the first latched move wins.
                if (frame_tick_q) begin
                    case (pend_dir_q)
                        DIR_UP:    row_d = step_dec(row_q);
                        DIR_DOWN:  row_d = step_inc(row_q);
                        DIR_LEFT:  col_d = step_dec(col_q);
                        DIR_RIGHT: col_d = step_inc(col_q);
                        default:   ;
                    endcase
                    state_d    = ST_IDLE;
                    pend_dir_d = DIR_NONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q      <= ST_IDLE;
            pend_dir_q   <= DIR_NONE;
            row_q        <= ROW_RST;
            col_q        <= COL_RST;
            vsync_q      <= 1'b1;
            frame_tick_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pend_dir_q   <= pend_dir_d;
            row_q        <= row_d;
            col_q        <= col_d;
            vsync_q      <= vsync_d;
            frame_tick_q <= frame_tick_d;
        end
    end

    assign player_address = {row_q, col_q};
    assign frame_tick     = frame_tick_q;
    assign move_pending   = (state_q == ST_PENDING);

endmodule

// File: tb/tb_player_mover.sv
// Bench for player_mover: directed scenarios plus random button/vsync
// activity, compared every cycle against a window-based reference model.
module tb_player_mover;

    localparam int D = 4;

    logic       clk;
    logic       rst;
    logic       vs;
    logic [3:0] btn;   // {up, down, left, right}, active-low
    logic [3:0] addr0, addr1;
    logic       ft0, ft1, mp0, mp1;

    int n_tests = 0;
    int n_fail  = 0;

    player_mover #(.DEBOUNCE_CYCLES(D), .START_ROW(0), .START_COL(0)) dut0 (
        .clk(clk), .rst(rst), .vsync(vs),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .player_address(addr0), .frame_tick(ft0), .move_pending(mp0)
    );

    player_mover #(.DEBOUNCE_CYCLES(D), .START_ROW(2), .START_COL(2)) dut1 (
        .clk(clk), .rst(rst), .vsync(vs),
        .btn_up(btn[3]), .btn_down(btn[2]), .btn_left(btn[1]), .btn_right(btn[0]),
        .player_address(addr1), .frame_tick(ft1), .move_pending(mp1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model state
    logic [3:0] m_dly[$];
    logic [3:0] m_hist[$];
    logic [3:0] m_db;
    int         m_press;   // 0 none, 1 up, 2 down, 3 left, 4 right
    bit         m_ft;
    bit         m_vs_prev;
    bit         m_pend;
    int         m_dir;
    int         m_row[2];
    int         m_col[2];

    task automatic chk(input string tag, input int got, input int exp);
        n_tests++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int sat(input int v);
        return (v < 0) ? 0 : ((v > 3) ? 3 : v);
    endfunction

    task automatic model_reset();
        m_dly.delete();
        m_dly.push_back(4'hF);
        m_dly.push_back(4'hF);
        m_hist.delete();
        m_db      = 4'hF;
        m_press   = 0;
        m_ft      = 1'b0;
        m_vs_prev = 1'b1;
        m_pend    = 1'b0;
        m_dir     = 0;
        m_row[0] = 0; m_col[0] = 0;
        m_row[1] = 2; m_col[1] = 2;
    endtask

    // One clock edge of the specified behaviour, using the inputs applied before it.
    task automatic model_step();
        logic [3:0] s;
        logic [3:0] pressed;
        bit         diff_all;
        if (!m_pend) begin
            if (m_press != 0) begin
                m_pend = 1'b1;
                m_dir  = m_press;
            end
        end else if (m_ft) begin
            for (int i = 0; i < 2; i++) begin
                case (m_dir)
                    1: m_row[i] = sat(m_row[i] - 1);
                    2: m_row[i] = sat(m_row[i] + 1);
                    3: m_col[i] = sat(m_col[i] - 1);
                    4: m_col[i] = sat(m_col[i] + 1);
                    default: ;
                endcase
            end
            m_pend = 1'b0;
        end
        m_ft      = m_vs_prev && !vs;
        m_vs_prev = vs;
        s = m_dly.pop_front();
        m_dly.push_back(btn);
        m_hist.push_back(s);
        if (m_hist.size() > D) void'(m_hist.pop_front());
        pressed = 4'b0;
        for (int b = 0; b < 4; b++) begin
            if (m_hist.size() == D) begin
                diff_all = 1'b1;
                for (int k = 0; k < D; k++)
                    if (m_hist[k][b] == m_db[b]) diff_all = 1'b0;
                if (diff_all) begin
                    pressed[b] = m_db[b];
                    m_db[b]    = ~m_db[b];
                end
            end
        end
        m_press = pressed[3] ? 1 : pressed[2] ? 2 : pressed[1] ? 3 : pressed[0] ? 4 : 0;
    endtask

    task automatic compare();
        chk("addr_s00", addr0, m_row[0] * 4 + m_col[0]);
        chk("addr_s22", addr1, m_row[1] * 4 + m_col[1]);
        chk("pend_s00", mp0, m_pend);
        chk("pend_s22", mp1, m_pend);
        chk("ftick_s00", ft0, m_ft);
        chk("ftick_s22", ft1, m_ft);
    endtask

    // Called at a negedge with inputs already set; returns at the next negedge.
    task automatic cyc();
        @(posedge clk);
        model_step();
        @(negedge clk);
        compare();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) cyc();
    endtask

    task automatic frame();
        vs = 1'b0;
        cyc();
        vs = 1'b1;
        run(3);
    endtask

    task automatic do_reset();
        @(negedge clk);
        btn = 4'hF;
        vs  = 1'b1;
        #2 rst = 1'b0;
        #1;
        chk("rst_addr_s00", addr0, 0);
        chk("rst_addr_s22", addr1, 10);
        chk("rst_pend", mp0, 0);
        chk("rst_ftick", ft0, 0);
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b1;
    endtask

    initial begin
        int first_pend;
        bit seen;
        int vs_cnt;
        int vs_low;

        rst = 1'b0;
        btn = 4'hF;
        vs  = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Single press: right held 10 cycles, then one frame.
        do_reset();
        btn = 4'b1110;
        first_pend = -1;
        for (int k = 1; k <= 10; k++) begin
            cyc();
            if (mp0 && first_pend < 0) first_pend = k;
        end
        chk("press_latency", first_pend, 7);
        btn = 4'hF;
        frame();
        chk("single_addr_s00", addr0, 1);
        chk("single_addr_s22", addr1, 11);

        // Bounce shorter than the debounce window never produces a press.
        do_reset();
        seen = 1'b0;
        for (int k = 0; k < 30; k++) begin
            if (k % 3 == 0) btn[2] = ~btn[2];
            cyc();
            if (mp0) seen = 1'b1;
        end
        btn = 4'hF;
        for (int k = 0; k < 10; k++) begin
            cyc();
            if (mp0) seen = 1'b1;
        end
        frame();
        chk("bounce_pend_seen", seen, 0);
        chk("bounce_addr", addr0, 0);

        // Priority (up over right) and first press wins over a later down.
        do_reset();
        btn = 4'b0110; run(8);
        btn = 4'hF;    run(8);
        btn = 4'b1011; run(8);
        btn = 4'hF;    run(8);
        chk("prio_pending", mp0, 1);
        frame();
        chk("prio_addr_s00", addr0, 0);
        chk("prio_addr_s22", addr1, 6);

        // Saturation at the right edge.
        do_reset();
        for (int n = 1; n <= 4; n++) begin
            btn = 4'b1110; run(8);
            btn = 4'hF;    run(8);
            frame();
            chk("sat_addr", addr0, (n < 3) ? n : 3);
        end

        // Press pulse coinciding with frame_tick while idle.
        do_reset();
        btn = 4'b1110;
        run(5);
        vs = 1'b0;
        cyc();
        chk("coll_ftick", ft0, 1);
        vs = 1'b1;
        cyc();
        chk("coll_pend", mp0, 1);
        chk("coll_addr_hold", addr0, 0);
        btn = 4'hF;
        run(8);
        chk("coll_addr_wait", addr0, 0);
        frame();
        chk("coll_addr_commit", addr0, 1);

        // Random button chatter and irregular frames.
        do_reset();
        vs_cnt = $urandom_range(20, 60);
        vs_low = 0;
        for (int k = 0; k < 3000; k++) begin
            for (int b = 0; b < 4; b++)
                if ($urandom_range(0, 11) == 0) btn[b] = ~btn[b];
            if (vs_low > 0) begin
                vs_low--;
                vs = (vs_low == 0);
            end else if (vs_cnt == 0) begin
                vs     = 1'b0;
                vs_low = $urandom_range(1, 2);
                vs_cnt = $urandom_range(20, 60);
            end else begin
                vs_cnt--;
            end
            cyc();
        end

        // Reset in the middle of activity.
        btn = 4'b0000;
        run(3);
        do_reset();
        run(20);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
